// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state geometry and the 5-bit S-box table.
package ascon_pack;

    localparam int unsigned NUM_WORDS = 5;
    localparam int unsigned WORD_W    = 64;

    typedef logic [WORD_W-1:0] type_word;
    typedef type_word [0:NUM_WORDS-1] type_state;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

endpackage

// File: rtl/substitution_layer_sbox.sv
// Single 5-bit ASCON S-box: combinational lookup, input bit 4 comes from word x0.
module substitution_layer_sbox
    import ascon_pack::*;
(
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    assign y_o = SBOX[x_i];

endmodule

// File: rtl/substitution_layer.sv
// ASCON substitution layer p_S: 64 parallel S-boxes over the bit-sliced state,
// result captured into an output register with a one-cycle valid pulse.
module substitution_layer
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      en_i,
    input  type_state sub_layer_i,
    output type_state sub_layer_o,
    output logic      valid_o
);

    logic [4:0] col_in  [WORD_W];
    logic [4:0] col_out [WORD_W];
    type_state  sub_layer_d;
    type_state  sub_layer_q;
    logic       valid_q;

    // Gather one bit per word into a column (x0 is the MSB) and substitute it.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_col
        assign col_in[gi] = {sub_layer_i[0][gi], sub_layer_i[1][gi],
                             sub_layer_i[2][gi], sub_layer_i[3][gi],
                             sub_layer_i[4][gi]};

        substitution_layer_sbox u_sbox (
            .x_i (col_in[gi]),
            .y_o (col_out[gi])
        );
    end

    always_comb begin
        sub_layer_d = '0;
        for (int j = 0; j < WORD_W; j++) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                sub_layer_d[k][j] = col_out[j][4-k];
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            sub_layer_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                sub_layer_q <= sub_layer_d;
            end
        end
    end

    assign sub_layer_o = sub_layer_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_substitution_layer.sv
// Directed bench for substitution_layer; reference uses the ASCON boolean S-box form.
module tb_substitution_layer;
    import ascon_pack::*;

    logic      clk;
    logic      resetb_i;
    logic      en_i;
    type_state sub_layer_i;
    type_state sub_layer_o;
    logic      valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    substitution_layer dut (
        .clock_i     (clk),
        .resetb_i    (resetb_i),
        .en_i        (en_i),
        .sub_layer_i (sub_layer_i),
        .sub_layer_o (sub_layer_o),
        .valid_o     (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s ok", tag);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-sliced boolean formulation of the ASCON S-box, independent of the table.
    function automatic type_state model(input type_state s);
        type_word x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        type_state r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic type_word rnd64();
        return {$urandom(), $urandom()};
    endfunction

    localparam type_word ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam type_word ONE  = 64'h0000000000000001;

    initial begin
        type_state s, exp_s, held;
        logic [4:0] v0, v63;

        resetb_i    = 1'b0;
        en_i        = 1'b0;
        sub_layer_i = '0;
        #2;
        chk("reset_state", sub_layer_o, '0);
        chk("reset_valid", {319'b0, valid_o}, 320'd0);

        en_i = 1'b1;
        sub_layer_i = '{ONES, ONES, ONES, ONES, ONES};
        tick();
        chk("reset_hold_state", sub_layer_o, '0);
        chk("reset_hold_valid", {319'b0, valid_o}, 320'd0);
        resetb_i = 1'b1;

        // Hand-derived vectors
        sub_layer_i = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        tick();
        exp_s = '{64'd0, 64'd0, ONES, 64'd0, 64'd0};
        chk("zero_state", sub_layer_o, exp_s);
        chk("zero_valid", {319'b0, valid_o}, 320'd1);

        sub_layer_i = '{ONES, ONES, ONES, ONES, ONES};
        tick();
        exp_s = '{ONES, 64'd0, ONES, ONES, ONES};
        chk("ones_state", sub_layer_o, exp_s);
        chk("ones_valid", {319'b0, valid_o}, 320'd1);

        sub_layer_i = '{ONE, 64'd0, 64'd0, 64'd0, 64'd0};
        tick();
        exp_s = '{ONE, ONE, ONES, ONE, 64'd0};
        chk("single_bit_state", sub_layer_o, exp_s);

        s = '{64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
              64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
        sub_layer_i = s;
        tick();
        held = model(s);
        chk("round_vec_state", sub_layer_o, held);
        chk("round_vec_valid", {319'b0, valid_o}, 320'd1);

        // Enable low: output holds despite changing input
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sub_layer_i = '{rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            tick();
            chk($sformatf("hold_state_%0d", i), sub_layer_o, held);
            chk($sformatf("hold_valid_%0d", i), {319'b0, valid_o}, 320'd0);
        end

        // Enable held high: new result every cycle
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = '{rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            sub_layer_i = s;
            tick();
            chk($sformatf("stream_state_%0d", i), sub_layer_o, model(s));
            chk($sformatf("stream_valid_%0d", i), {319'b0, valid_o}, 320'd1);
        end

        // All 32 column values on columns 0 and 63
        for (int v = 0; v < 32; v++) begin
            v0  = 5'(v);
            v63 = 5'(31 - v);
            s = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
            for (int k = 0; k < 5; k++) begin
                s[k][0]  = v0[4-k];
                s[k][63] = v63[4-k];
            end
            sub_layer_i = s;
            tick();
            chk($sformatf("sweep_%0d", v), sub_layer_o, model(s));
        end

        // Asynchronous reset between edges
        #2;
        resetb_i = 1'b0;
        #1;
        chk("async_reset_state", sub_layer_o, '0);
        chk("async_reset_valid", {319'b0, valid_o}, 320'd0);
        tick();
        chk("async_reset_hold", sub_layer_o, '0);

        s = '{64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
              64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
        sub_layer_i = s;
        resetb_i = 1'b1;
        tick();
        chk("post_reset_state", sub_layer_o, model(s));
        chk("post_reset_valid", {319'b0, valid_o}, 320'd1);
        en_i = 1'b0;
        tick();
        chk("post_reset_pulse_end", {319'b0, valid_o}, 320'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
